uart_transmitter: RTL and testbench

Serial UART transmitter: the transmit-side counterpart of the team's UART receiver, same frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit. Accepts bytes over a valid/ready handshake into a one-byte holding register, so frames can go back-to-back with no idle gap. Sits between the fabric-side byte source and the board TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 24 ++
 rtl/uart_transmitter.sv | 113 +++++++++++
 tb/tb_uart_transmitter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and baud helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  // 1: parity bit makes the total count of ones even (bit = XOR of data)
  localparam bit UART_PARITY_EVEN = 1'b1;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d);
    return (^d) ^ !UART_PARITY_EVEN;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] clk_cnt;

  assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wrap only at the end of a bit period; clear holds the count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   clk_cnt <= '0;
    else if (clear || bit_end) clk_cnt <= '0;
    else                       clk_cnt <= clk_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, 8 data LSB first, even parity, 1 stop.
// One-byte holding register lets frames run back-to-back with no idle gap.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  uart_state_e state, state_nx;

  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      hold_full;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      parity;
  logic [2:0]                bit_idx, bit_nx;
  logic                      bit_end;
  logic                      accept;
  logic                      load;
  logic                      tx_d;

  assign tx_ready = !hold_full;
  assign accept   = tx_valid && tx_ready;
  // FSM takes the held byte from IDLE, or straight out of the last stop cycle
  assign load     = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy     = (state != IDLE);
  assign tx_done  = (state == STOP) && bit_end;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  // Holding register: accept and drain never collide (accept needs it empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (accept)    hold_data <= tx_data;
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
    end
  end

  // Frame datapath: byte and parity latched at load, bit index steps per data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      parity    <= 1'b0;
      bit_idx   <= '0;
    end else if (load) begin
      shift_reg <= hold_data;
      parity    <= uart_parity(hold_data);
      bit_idx   <= '0;
    end else if ((state == DATA) && bit_end) begin
      bit_idx   <= bit_nx;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hold_full) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && (bit_idx == 3'(UART_DATA_BITS - 1))) state_nx = PARITY;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:    if (bit_end) state_nx = hold_full ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line value for the upcoming cycle, so the registered tx lines up with state.
  always_comb begin
    bit_nx = bit_idx;
    if ((state == DATA) && bit_end) bit_nx = bit_idx + 3'd1;
    tx_d = 1'b1;
    unique case (state_nx)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_reg[bit_nx];
      PARITY:  tx_d = parity;
      default: tx_d = 1'b1;
    endcase
  end

  // Registered line output; reset forces the idle level immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx <= 1'b1;
    else     tx <= tx_d;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: scoreboard of expected bytes, line-decoding monitor.
module tb_uart_transmitter;

  localparam int CPB   = 10;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, tx_done;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stray_done = 0;
  bit   cnt_en = 1'b0;
  int   rdy_lo = 0;
  int   busy_hi = 0;

  uart_transmitter #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: detects each start bit, walks the whole frame cycle by cycle and
  // compares it against the next expected byte.
  initial begin : monitor
    exp_t       e;
    bit         has_exp;
    logic [10:0] fb;
    int         bad_off, dcnt, doff, busy_lo;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        has_exp = (exp_q.size() != 0);
        if (has_exp) e = exp_q.pop_front();
        else begin
          e.d = 8'h00;
          e.p = 1'b0;
          chk("unexpected_frame", 1, 0);
        end
        fb = {1'b1, e.p, e.d, 1'b0};
        bad_off = -1; dcnt = 0; doff = -1; busy_lo = 0; aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== fb[k / CPB] && bad_off < 0) bad_off = k;
          if (tx_done) begin
            dcnt++;
            doff = k;
          end
          if (!busy) busy_lo++;
        end
        if (!aborted && has_exp) begin
          chk($sformatf("line_%02h_first_bad_cycle", e.d), bad_off, -1);
          chk($sformatf("done_count_%02h", e.d), dcnt, 1);
          chk($sformatf("done_cycle_%02h", e.d), doff, FRAME - 1);
          chk($sformatf("busy_gaps_%02h", e.d), busy_lo, 0);
        end
      end else if (!rst && tx_done) begin
        stray_done++;
      end
    end
  end

  // Handshake/busy activity counters for the back-to-back window.
  initial begin : counters
    forever begin
      @(negedge clk);
      if (cnt_en) begin
        if (!tx_ready) rdy_lo++;
        if (busy) busy_hi++;
      end
    end
  end

  // Offer a byte and hold tx_valid until it is taken; returns the accept cycle.
  task automatic send(input logic [7:0] d, input logic p, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    exp_q.push_back('{d, p});
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || !tx_ready) && n < 5000);
    chk(name, (exp_q.size() == 0 && !busy && tx_ready) ? 1 : 0, 1);
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
    if (!ok) chk("start_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  a1, a2, n, lo, dn, bz;
    bit  ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", tx_done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x55: start edge two cycles after accept
    send(8'h55, 1'b0, a1);
    drop();
    wait_start(ok);
    if (ok) chk("start_latency", cyc - a1, 2);
    drain("drain_55");

    // 0x07 has odd weight, so the parity slot carries a 1
    send(8'h07, 1'b1, a1);
    drop();
    wait_start(ok);
    if (ok) begin
      repeat (95) @(negedge clk);
      chk("parity_slot_07", tx, 1);
    end
    drain("drain_07");

    // Back-to-back 0xA5, 0x3C with tx_valid held
    start_q.delete();
    rdy_lo  = 0;
    busy_hi = 0;
    cnt_en  = 1'b1;
    send(8'hA5, 1'b0, a1);
    send(8'h3C, 1'b0, a2);
    drop();
    drain("drain_b2b");
    cnt_en = 1'b0;
    chk("b2b_frames", start_q.size(), 2);
    if (start_q.size() >= 2) begin
      chk("second_accept_in_start", (a2 >= start_q[0] && a2 < start_q[0] + CPB) ? 1 : 0, 1);
      chk("b2b_start_spacing", start_q[1] - start_q[0], FRAME);
    end
    chk("b2b_busy_cycles", busy_hi, 2 * FRAME);
    chk("b2b_ready_low_cycles", rdy_lo, 110);

    // Backpressure: three bytes offered continuously
    start_q.delete();
    send(8'h01, 1'b1, a1);
    send(8'h02, 1'b1, a1);
    send(8'h03, 1'b0, a1);
    drop();
    drain("drain_bp");
    chk("bp_frames", start_q.size(), 3);

    // Reset during data bit 4 of 0xFF with 0x5A held
    start_q.delete();
    send(8'hFF, 1'b0, a1);
    send(8'h5A, 1'b0, a2);
    drop();
    n = 0;
    while (start_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ff_started", start_q.size(), 1);
    if (start_q.size() != 0) begin
      n = 0;
      while (cyc < start_q[0] + 54 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("ff_in_bit4_line", tx, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", tx_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lo = 0; dn = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lo++;
      if (tx_done) dn++;
    end
    chk("postrst_line_low", lo, 0);
    chk("postrst_done", dn, 0);
    chk("postrst_ready", tx_ready, 1);

    // Idle for 1000 cycles
    lo = 0; dn = 0; bz = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lo++;
      if (busy) bz++;
      if (tx_done) dn++;
    end
    chk("idle_line_low", lo, 0);
    chk("idle_busy", bz, 0);
    chk("idle_done", dn, 0);

    chk("stray_done", stray_done, 0);
    chk("leftover_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
